// File: rtl/fim_rdack_axis_bridge_if.sv
// rtl/fim_rdack_axis_bridge_if.sv - rdack-FIFO upstream and valid/ready downstream signal bundle
interface fim_rdack_axis_bridge_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdack;
  logic                  o_tvalid;
  logic [DATA_WIDTH-1:0] o_tdata;
  logic                  o_tready;

  modport slave (
    input  rvalid, rdata, o_tready,
    output rdack, o_tvalid, o_tdata
  );

  modport master (
    output rvalid, rdata, o_tready,
    input  rdack, o_tvalid, o_tdata
  );
endinterface

// File: rtl/fim_rdack_axis_bridge.sv
// rtl/fim_rdack_axis_bridge.sv - show-ahead FIFO (rdack) to valid/ready stream bridge, 2-entry skid buffer
// Optional beat counter enabled by FIM_RDACK_AXIS_BEAT_CNT_EN.
module fim_rdack_axis_bridge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          sclr,
  fim_rdack_axis_bridge_if.slave        bus
`ifdef FIM_RDACK_AXIS_BEAT_CNT_EN
  ,
  output logic [31:0]                   beat_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  full_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  rdack;
  logic                  push;
  logic                  pop;

  // rdack depends only on registered fullness, so o_tready never reaches it combinationally
  assign rdack = bus.rvalid & ~full_q & ~sclr;
  assign push  = bus.rvalid & rdack;
  assign pop   = valid_q & bus.o_tready;

  assign bus.rdack    = rdack;
  assign bus.o_tvalid = valid_q;
  assign bus.o_tdata  = head_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = bus.rdata;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = bus.rdata;
        end else if (push) begin
          state_d = TWO;
          tail_d  = bus.rdata;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= EMPTY;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= (state_d == TWO);
      valid_q <= (state_d != EMPTY);
    end
  end

  // Data registers carry no reset; o_tdata is only meaningful while o_tvalid is high
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

`ifdef FIM_RDACK_AXIS_BEAT_CNT_EN
  logic [31:0] beat_cnt_q;

  always_ff @(posedge clk) begin
    if (sclr) begin
      beat_cnt_q <= 32'd0;
    end else if (pop) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_fim_rdack_axis_bridge.sv
// tb/tb_fim_rdack_axis_bridge.sv - scoreboard bench for fim_rdack_axis_bridge
module tb_fim_rdack_axis_bridge;

  logic clk;
  logic sclr;
  int   checks;
  int   errors;
  int   cyc;
  bit   lat_chk;
  bit   prev_stall;
  bit   was_rst;
  logic [31:0] prev_data;

  logic [31:0] src[$];
  logic [31:0] exp_d[$];
  int          exp_c[$];

  fim_rdack_axis_bridge_if #(.DATA_WIDTH(32)) bus ();

`ifdef FIM_RDACK_AXIS_BEAT_CNT_EN
  logic [31:0] beat_cnt;
`endif

  fim_rdack_axis_bridge #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .sclr     (sclr),
    .bus      (bus)
`ifdef FIM_RDACK_AXIS_BEAT_CNT_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One bench cycle: drive at negedge, then model the upstream FIFO consuming on rdack
  task automatic cyc_drive(input bit rv, input bit rdy, input bit rst);
    @(negedge clk);
    sclr         = rst;
    bus.o_tready = rdy;
    bus.rvalid   = rv && (src.size() > 0);
    if (src.size() > 0) bus.rdata = src[0];
    #1;
    if (bus.rvalid && bus.rdack) begin
      exp_d.push_back(src.pop_front());
      exp_c.push_back(cyc);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (sclr) begin
      chk("rst_rdack", {63'd0, bus.rdack}, 64'd0);
      exp_d.delete();
      exp_c.delete();
      prev_stall = 1'b0;
      was_rst    = 1'b1;
    end else begin
      if (was_rst) begin
        chk("rst_tvalid", {63'd0, bus.o_tvalid}, 64'd0);
`ifdef FIM_RDACK_AXIS_BEAT_CNT_EN
        chk("rst_beat_cnt", {32'd0, beat_cnt}, 64'd0);
`endif
      end
      if (bus.rdack) chk("rdack_needs_rvalid", {63'd0, bus.rvalid}, 64'd1);
      if (prev_stall) begin
        chk("stall_tvalid", {63'd0, bus.o_tvalid}, 64'd1);
        chk("stall_tdata", {32'd0, bus.o_tdata}, {32'd0, prev_data});
      end
      if (bus.o_tvalid && bus.o_tready) begin
        if (exp_d.size() == 0) begin
          chk("unexpected_beat", {32'd0, bus.o_tdata}, 64'hDEAD_0000_0000_0000);
        end else begin
          int pc;
          chk("beat_data", {32'd0, bus.o_tdata}, {32'd0, exp_d.pop_front()});
          pc = exp_c.pop_front();
          if (lat_chk) chk("beat_latency", 64'(cyc), 64'(pc + 1));
        end
      end
      prev_stall = bus.o_tvalid && !bus.o_tready;
      prev_data  = bus.o_tdata;
      was_rst    = 1'b0;
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    lat_chk      = 1'b0;
    prev_stall   = 1'b0;
    was_rst      = 1'b0;
    prev_data    = '0;
    sclr         = 1'b1;
    bus.rvalid   = 1'b0;
    bus.rdata    = '0;
    bus.o_tready = 1'b0;

    repeat (3) cyc_drive(0, 0, 1);
    cyc_drive(0, 0, 0);
    chk("idle_tvalid", {63'd0, bus.o_tvalid}, 64'd0);

    // Streaming 0x1..0x10, one beat per cycle
    for (int i = 1; i <= 16; i++) src.push_back(32'(i));
    lat_chk = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc_drive(1, 1, 0);
      chk("stream_rdack", {63'd0, bus.rdack}, 64'd1);
    end
    repeat (3) cyc_drive(0, 1, 0);
    chk("stream_drained", 64'(exp_d.size()), 64'd0);

    // Sparse input: 0x55 and 0x66 every third cycle
    src.push_back(32'h55);
    src.push_back(32'h66);
    for (int i = 0; i < 2; i++) begin
      cyc_drive(1, 1, 0);
      chk("sparse_rdack", {63'd0, bus.rdack}, 64'd1);
      cyc_drive(0, 1, 0);
      chk("sparse_tvalid_hi", {63'd0, bus.o_tvalid}, 64'd1);
      cyc_drive(0, 1, 0);
      chk("sparse_tvalid_lo", {63'd0, bus.o_tvalid}, 64'd0);
    end
    lat_chk = 1'b0;

    // Backpressure: 0xA, 0xB fill the buffer, 0xC waits
    src.push_back(32'hA);
    src.push_back(32'hB);
    src.push_back(32'hC);
    cyc_drive(1, 0, 0);
    chk("bp_rdack0", {63'd0, bus.rdack}, 64'd1);
    cyc_drive(1, 0, 0);
    chk("bp_rdack1", {63'd0, bus.rdack}, 64'd1);
    chk("bp_head", {32'd0, bus.o_tdata}, 64'hA);
    cyc_drive(1, 0, 0);
    chk("bp_full_rdack", {63'd0, bus.rdack}, 64'd0);
    chk("bp_hold", {32'd0, bus.o_tdata}, 64'hA);
    cyc_drive(1, 1, 0);
    chk("bp_pop_rdack", {63'd0, bus.rdack}, 64'd0);
    chk("bp_pop_a", {32'd0, bus.o_tdata}, 64'hA);
    cyc_drive(1, 1, 0);
    chk("bp_reack", {63'd0, bus.rdack}, 64'd1);
    chk("bp_pop_b", {32'd0, bus.o_tdata}, 64'hB);
    repeat (3) cyc_drive(0, 1, 0);
    chk("bp_drained", 64'(exp_d.size()), 64'd0);

    // Reset mid-operation with 0x1, 0x2 buffered; 0x9 must be the next beat
    src.push_back(32'h1);
    src.push_back(32'h2);
    src.push_back(32'h9);
    repeat (3) cyc_drive(1, 0, 0);
    chk("rst_mid_full", {63'd0, bus.rdack}, 64'd0);
    cyc_drive(1, 0, 1);
    cyc_drive(1, 1, 0);
    chk("rst_mid_rdack", {63'd0, bus.rdack}, 64'd1);
    cyc_drive(0, 1, 0);
    chk("rst_mid_next", {32'd0, bus.o_tdata}, 64'h9);
    chk("rst_mid_tvalid", {63'd0, bus.o_tvalid}, 64'd1);
    repeat (2) cyc_drive(0, 1, 0);

    // Random rvalid / o_tready
    for (int i = 0; i < 10000; i++) begin
      if (src.size() < 4) src.push_back($urandom);
      cyc_drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    src.delete();
    repeat (4) cyc_drive(0, 1, 0);
    chk("random_drained", 64'(exp_d.size()), 64'd0);

`ifdef FIM_RDACK_AXIS_BEAT_CNT_EN
    // Counter wrap: preload 0xFFFFFFFE, then three pops
    @(negedge clk);
    force dut.beat_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.beat_cnt_q;
    src.push_back(32'h7);
    src.push_back(32'h8);
    src.push_back(32'h9);
    for (int k = 1; k <= 5; k++) begin
      cyc_drive(k <= 3, 1, 0);
      if (k == 3) chk("cnt_ffffffff", {32'd0, beat_cnt}, 64'hFFFF_FFFF);
      if (k == 4) chk("cnt_wrap0", {32'd0, beat_cnt}, 64'h0);
      if (k == 5) chk("cnt_one", {32'd0, beat_cnt}, 64'h1);
    end
    repeat (2) cyc_drive(0, 1, 0);
`endif

    chk("final_sb_empty", 64'(exp_d.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
